// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
//   RV_NOP     : canonical RISC-V NOP (addi x0, x0, 0)
//   pipe_state_e : occupancy of a stage register (EMPTY / ONE / FULL)
//   make_bubble: builds a {pc, instr} bubble payload carrying a NOP
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Bubble for instruction-carrying stages: the pc field is a don't-care
    // for a NOP, so callers pass whatever value keeps the trace readable.
    function automatic logic [63:0] make_bubble(input logic [31:0] pc);
        return {pc, RV_NOP};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : add one this cycle (ignored once the counter is at its maximum)
//   q     : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_r;

    // Count register: holds at CNT_MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != CNT_MAX)) begin
            q_r <= q_r + CNT_ONE;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register between two pipeline stages.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : drop every held entry (and any same-cycle accept)
//   up_valid/up_ready/up_data : upstream handshake and payload
//   dn_valid/dn_ready/dn_data : downstream handshake and payload; dn_data is
//                          BUBBLE whenever dn_valid is low
//   stall_cnt            : saturating count of cycles with dn_valid & !dn_ready
//   flush_cnt            : saturating count of flush cycles while occupied
// With SKID_EN = 1 a second (skid) entry lets up_ready come straight from the
// state register; with SKID_EN = 0 up_ready depends combinationally on dn_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  BUBBLE  = DATA_W'(make_bubble(32'h0000_0000)),
    parameter int                 SKID_EN = 1,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e       state_r;
    pipe_state_e       next_state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_next_s;
    logic [DATA_W-1:0] skid_s;
    logic              up_fire_s;
    logic              dn_fire_s;

    assign dn_valid  = (state_r != EMPTY);
    assign dn_data   = main_r;
    assign up_fire_s = up_valid & up_ready;
    assign dn_fire_s = dn_valid & dn_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic [DATA_W-1:0] skid_r;

            // Skid entry: captures the arrival that could not move into main
            // because downstream stalled while main was occupied.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_r <= BUBBLE;
                end else if (!flush && (state_r == ONE) && up_fire_s && !dn_fire_s) begin
                    skid_r <= up_data;
                end else begin
                    skid_r <= skid_r;
                end
            end

            assign skid_s   = skid_r;
            assign up_ready = (state_r != FULL);
        end else begin : g_no_skid
            assign skid_s   = BUBBLE;
            assign up_ready = !dn_valid | dn_ready;
        end
    endgenerate

    // State and main-entry register; main_r is loaded with BUBBLE whenever
    // the register empties so stale payload never reaches dn_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            main_r  <= BUBBLE;
        end else begin
            state_r <= next_state_s;
            main_r  <= main_next_s;
        end
    end

    // Next-state and next-main decode; flush overrides every transfer.
    always_comb begin
        next_state_s = state_r;
        main_next_s  = main_r;
        if (flush) begin
            next_state_s = EMPTY;
            main_next_s  = BUBBLE;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (up_fire_s) begin
                        next_state_s = ONE;
                        main_next_s  = up_data;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (up_fire_s && dn_fire_s) begin
                        main_next_s = up_data;
                    end else if (up_fire_s) begin
                        // Only reachable with a skid entry; without one
                        // up_ready is low whenever main is held and not taken.
                        next_state_s = (SKID_EN != 0) ? FULL : ONE;
                    end else if (dn_fire_s) begin
                        next_state_s = EMPTY;
                        main_next_s  = BUBBLE;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                FULL: begin
                    if (dn_fire_s) begin
                        next_state_s = ONE;
                        main_next_s  = skid_s;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                    main_next_s  = BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dn_valid & !dn_ready),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush & (state_r != EMPTY)),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Three instances share stimulus: dut (skid, 16-bit counters), dut4 (skid,
// 4-bit counters) and dut0 (no skid). Each test resets first and checks only
// the instance(s) it targets.
module tb_pipe_stage_reg;

    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        dn_ready;
    logic [63:0] up_data;

    logic        up_ready, dn_valid;
    logic [63:0] dn_data;
    logic [15:0] stall_cnt, flush_cnt;

    logic        up_ready4, dn_valid4;
    logic [63:0] dn_data4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    logic        up_ready0, dn_valid0;
    logic [63:0] dn_data0;
    logic [15:0] stall_cnt0, flush_cnt0;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.SKID_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.SKID_EN(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready4), .up_data(up_data),
        .dn_valid(dn_valid4), .dn_ready(dn_ready), .dn_data(dn_data4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    pipe_stage_reg #(.SKID_EN(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready0), .up_data(up_data),
        .dn_valid(dn_valid0), .dn_ready(dn_ready), .dn_data(dn_data0),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pay(input int i);
        logic [31:0] pc;
        logic [31:0] ins;
        pc  = 32'h0000_0100 + 32'(4 * i);
        ins = 32'h0000_00A0 + 32'(i);
        return {pc, ins};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = 64'h0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", dn_valid); end
        checks++; if (dn_data !== BUB) begin errors++; $display("FAIL reset_data: got %h expected %h", dn_data, BUB); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready: got %0b expected 1", up_ready); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        // accept one entry, then drop reset between edges
        up_valid = 1'b1; up_data = pay(40);
        tick;
        checks++; if (dn_valid !== 1'b1 || dn_data !== pay(40)) begin errors++; $display("FAIL pre_async_load: got %0b/%h expected 1/%h", dn_valid, dn_data, pay(40)); end
        up_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (dn_valid !== 1'b0 || dn_data !== BUB) begin errors++; $display("FAIL async_reset: got %0b/%h expected 0/%h", dn_valid, dn_data, BUB); end
        #1;
        rst_n = 1'b1;
        tick;
        checks++; if (dn_valid !== 1'b0 || up_ready !== 1'b1) begin errors++; $display("FAIL after_async_release: got valid=%0b ready=%0b expected 0/1", dn_valid, up_ready); end
    endtask

    task automatic test_stream;
        do_reset;
        dn_ready = 1'b1; up_valid = 1'b1; up_data = pay(0);
        for (int i = 0; i < 8; i++) begin
            tick;
            checks++; if (dn_valid !== 1'b1 || dn_data !== pay(i)) begin errors++; $display("FAIL stream_data[%0d]: got %0b/%h expected 1/%h", i, dn_valid, dn_data, pay(i)); end
            checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL stream_up_ready[%0d]: got %0b expected 1", i, up_ready); end
            if (i < 7) up_data = pay(i + 1);
            else up_valid = 1'b0;
        end
        tick;
        checks++; if (dn_valid !== 1'b0 || dn_data !== BUB) begin errors++; $display("FAIL stream_drain: got %0b/%h expected 0/%h", dn_valid, dn_data, BUB); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_backpressure;
        do_reset;
        dn_ready = 1'b0; up_valid = 1'b1; up_data = pay(10);
        tick;
        checks++; if (dn_data !== pay(10) || up_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got %h/%0b expected %h/1", dn_data, up_ready, pay(10)); end
        up_data = pay(11);
        tick;
        checks++; if (up_ready !== 1'b0 || dn_data !== pay(10)) begin errors++; $display("FAIL bp_full: got ready=%0b data=%h expected 0/%h", up_ready, dn_data, pay(10)); end
        up_data = pay(12);
        tick;
        checks++; if (up_ready !== 1'b0 || stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stalled: got ready=%0b stall=%0d expected 0/2", up_ready, stall_cnt); end
        dn_ready = 1'b1;
        tick;
        checks++; if (dn_data !== pay(11) || up_ready !== 1'b1) begin errors++; $display("FAIL bp_out1: got %h/%0b expected %h/1", dn_data, up_ready, pay(11)); end
        tick;
        checks++; if (dn_valid !== 1'b1 || dn_data !== pay(12)) begin errors++; $display("FAIL bp_out2: got %0b/%h expected 1/%h", dn_valid, dn_data, pay(12)); end
        up_valid = 1'b0;
        tick;
        checks++; if (dn_valid !== 1'b0 || dn_data !== BUB) begin errors++; $display("FAIL bp_drain: got %0b/%h expected 0/%h", dn_valid, dn_data, BUB); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_flush;
        do_reset;
        dn_ready = 1'b0; up_valid = 1'b1; up_data = pay(20);
        tick;
        up_data = pay(21);
        tick;
        flush = 1'b1; up_data = pay(22);
        tick;
        checks++; if (dn_valid !== 1'b0 || dn_data !== BUB) begin errors++; $display("FAIL flush_full: got %0b/%h expected 0/%h", dn_valid, dn_data, BUB); end
        checks++; if (up_ready !== 1'b1 || flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_ready_cnt: got %0b/%0d expected 1/1", up_ready, flush_cnt); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_keeps_stall: got %0d expected 2", stall_cnt); end
        flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
        tick;
        checks++; if (dn_valid !== 1'b0 || dn_data !== BUB) begin errors++; $display("FAIL flush_no_resurrect: got %0b/%h expected 0/%h", dn_valid, dn_data, BUB); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_empty_not_counted: got %0d expected 1", flush_cnt); end
        flush = 1'b1; rst_n = 1'b0;
        #1;
        checks++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_reset_together: got %0d/%0d expected 0/0", flush_cnt, stall_cnt); end
        tick;
        flush = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_saturation;
        do_reset;
        dn_ready = 1'b0; up_valid = 1'b1; up_data = pay(30);
        tick;
        up_valid = 1'b0;
        checks++; if (dn_valid4 !== 1'b1 || dn_data4 !== pay(30) || up_ready4 !== 1'b1) begin errors++; $display("FAIL sat_load: got %0b/%h/%0b expected 1/%h/1", dn_valid4, dn_data4, up_ready4, pay(30)); end
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 14) begin
                checks++; if (stall_cnt4 !== 4'd14) begin errors++; $display("FAIL sat_count14: got %0d expected 14", stall_cnt4); end
            end
            if (k == 15) begin
                checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_count15: got %0d expected 15", stall_cnt4); end
            end
        end
        checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'd20 || flush_cnt4 !== 4'd0) begin errors++; $display("FAIL sat_wide: got %0d/%0d expected 20/0", stall_cnt, flush_cnt4); end
    endtask

    task automatic test_no_skid;
        do_reset;
        dn_ready = 1'b1; up_valid = 1'b1; up_data = pay(50);
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (dn_valid0 !== 1'b1 || dn_data0 !== pay(50 + i)) begin errors++; $display("FAIL noskid_data[%0d]: got %0b/%h expected 1/%h", i, dn_valid0, dn_data0, pay(50 + i)); end
            if (i < 3) up_data = pay(51 + i);
        end
        up_data = pay(54); dn_ready = 1'b0;
        #1;
        checks++; if (up_ready0 !== 1'b0) begin errors++; $display("FAIL noskid_ready_low: got %0b expected 0", up_ready0); end
        tick;
        checks++; if (dn_data0 !== pay(53)) begin errors++; $display("FAIL noskid_hold: got %h expected %h", dn_data0, pay(53)); end
        dn_ready = 1'b1;
        #1;
        checks++; if (up_ready0 !== 1'b1) begin errors++; $display("FAIL noskid_ready_high: got %0b expected 1", up_ready0); end
        tick;
        up_valid = 1'b0;
        checks++; if (dn_data0 !== pay(54)) begin errors++; $display("FAIL noskid_replace: got %h expected %h", dn_data0, pay(54)); end
        checks++; if (stall_cnt0 !== 16'd1 || flush_cnt0 !== 16'd0) begin errors++; $display("FAIL noskid_counters: got %0d/%0d expected 1/0", stall_cnt0, flush_cnt0); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_flush;
        test_saturation;
        test_no_skid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, an optional skid entry, flush-to-bubble and saturating stall/flush counters. It replaces the fixed-width, pause-based stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. The upstream stage offers a payload such as {pc, instr}. The downstream stage takes it one cycle later. When the register holds no valid entry, its output is the configured bubble, a NOP for instruction-carrying stages.

## Interface
Parameters:
- `DATA_W`, 64, payload width in bits; for IF/ID the payload is {pc[31:0], instr[31:0]}.
- `BUBBLE`, {32'h0, 32'h0000_0013}, value driven on `dn_data` when no valid entry is held; width `DATA_W`.
- `SKID_EN`, 1; 1 = two-entry skid buffer with a registered `up_ready`; 0 = single entry with a combinational `up_ready`.
- `CNT_W`, 16, width of the performance counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all held entries; takes priority over everything except reset.
- `up_valid` in 1: upstream offers `up_data`.
- `up_ready` out 1: register accepts this cycle.
- `up_data` in `DATA_W`: upstream payload.
- `dn_valid` out 1: `dn_data` holds a valid entry.
- `dn_ready` in 1: downstream takes the entry this cycle.
- `dn_data` out `DATA_W`: main entry, or `BUBBLE` when `dn_valid` = 0.
- `stall_cnt` out `CNT_W`: number of cycles with `dn_valid` & !`dn_ready`; saturates.
- `flush_cnt` out `CNT_W`: number of cycles with `flush` = 1 while any entry was valid; saturates.

## Operation
- Transfers: up_fire = `up_valid` & `up_ready`; dn_fire = `dn_valid` & `dn_ready`.
- States (SKID_EN = 1):
  - EMPTY: no valid entry.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Transitions (SKID_EN = 1):
  - EMPTY: up_fire -> ONE, main <= `up_data`.
  - ONE: up_fire & dn_fire -> ONE, main <= `up_data`.
  - ONE: up_fire & !dn_fire -> FULL, skid <= `up_data`.
  - ONE: !up_fire & dn_fire -> EMPTY.
  - FULL: dn_fire -> ONE, main <= skid. `up_ready` = 0 in FULL, so no up_fire is possible.
- `up_ready` (SKID_EN = 1) = state != FULL, decoded from registered state only.
- SKID_EN = 0: only EMPTY and ONE are used. `up_ready` = !`dn_valid` | `dn_ready`, a combinational path from `dn_ready`. Simultaneous up_fire and dn_fire replaces main.
- Entries leave strictly in arrival order; no entry is duplicated or dropped except by `flush`.
- `flush` = 1: next state is EMPTY and the main and skid entries are invalidated. An up_fire in the same cycle is discarded. `dn_data` returns to `BUBBLE`.
- `dn_data` is a registered value: main when valid, else `BUBBLE`. Stale payload is never exposed.
- Counters: increment by 1 per qualifying cycle and stop at 2^CNT_W-1. Only reset clears them; `flush` does not.

## Timing
- Latency: `up_data` accepted at edge N is on `dn_data` after edge N; 1 cycle.
- Throughput: 1 entry/cycle while `dn_ready` = 1.
- Reset (`rst_n` = 0, asynchronous): state EMPTY, `dn_valid` 0, `dn_data` `BUBBLE`, `up_ready` 1, `stall_cnt` 0, `flush_cnt` 0.
- Reset asserted mid-transfer: all entries are lost immediately, without waiting for a clock edge. After release, the first edge behaves as EMPTY.
- `flush` and `rst_n` low together: reset wins; counters read 0.
- Counter boundary: at 2^CNT_W-1 a further qualifying cycle leaves the value unchanged; no wrap to 0.
- `flush` in FULL: both entries are lost in one cycle; `up_ready` returns to 1 on the next cycle.

## Structure
- Shared package `pipe_pkg`:
  - `RV_NOP` = 32'h0000_0013.
  - State enum {EMPTY, ONE, FULL}.
  - Default `BUBBLE` construction helper for {pc, instr} payloads.
- Sub-module `sat_counter` (parameter `W`; inputs `clk`, `rst_n`, `inc`; output `q`), instantiated twice.
- Skid storage sits under a generate on `SKID_EN`; with SKID_EN = 0 no skid flops exist.

## Test plan
- Reset release, idle, SKID_EN = 1: `dn_valid` = 0, `dn_data` = 64'h0000_0000_0000_0013, `up_ready` = 1.
- Stream of 8 payloads {pc = 0x100+4i, instr = 0xA0+i} with `dn_ready` held 1: `dn_data` equals the payload one cycle after acceptance; no gaps.
- Backpressure: 3 payloads while `dn_ready` = 0 -> first two held (FULL), `up_ready` = 0, third stalls upstream. Then `dn_ready` = 1 -> outputs in order 0,1,2; `stall_cnt` = number of stalled cycles.
- `flush` in FULL while `up_valid` = 1: next cycle `dn_valid` = 0, `dn_data` = `BUBBLE`, flushed payloads never appear downstream, `flush_cnt` = 1.
- CNT_W = 4 with `dn_ready` held 0 for 20 cycles: `stall_cnt` stops at 15.
- SKID_EN = 0: `up_ready` tracks `dn_ready` in the same cycle while `dn_valid` = 1; ordering and latency as in the stream test.
